dallanma_birimi: RTL and testbench

//  Parametrised program-counter and control-flow unit for the multicycle islemci.

---
 rtl/dallanma_pkg.sv | 58 +++++
 rtl/dallanma_birimi_if.sv | 33 +++
 rtl/dallanma_karsilastirici.sv | 33 +++
 rtl/dallanma_birimi.sv | 119 +++++++++++
 tb/tb_dallanma_birimi.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dallanma_pkg.sv
// Package: dallanma_pkg
// Shared definitions for the control-flow unit: stage encodings, instruction
// kind encodings, RV opcode and branch funct3 constants, and the decode helpers
// that turn a raw instruction word into its kind and sign-extended immediate.
package dallanma_pkg;

    typedef enum logic [1:0] {
        GETIR        = 2'd0,
        COZYAZMACOKU = 2'd1,
        YURUTGERIYAZ = 2'd2
    } asama_t;

    typedef enum logic [1:0] {
        TUR_DIGER = 2'd0,
        TUR_DAL   = 2'd1,
        TUR_JAL   = 2'd2,
        TUR_JALR  = 2'd3
    } tur_t;

    localparam logic [6:0] OP_DAL  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;

    function automatic tur_t tur_coz(input logic [6:0] opcode);
        tur_t t;
        case (opcode)
            OP_DAL:  t = TUR_DAL;
            OP_JAL:  t = TUR_JAL;
            OP_JALR: t = TUR_JALR;
            default: t = TUR_DIGER;
        endcase
        return t;
    endfunction

    // Immediate for the control-flow formats, sign-extended to 32 bits.
    // Non-control-flow opcodes return zero; their immediate is never used here.
    function automatic logic [31:0] imm_coz(input logic [31:0] b);
        logic [31:0] imm;
        case (b[6:0])
            OP_DAL:  imm = {{20{b[31]}}, b[7], b[30:25], b[11:8], 1'b0};
            OP_JAL:  imm = {{12{b[31]}}, b[19:12], b[20], b[30:21], 1'b0};
            OP_JALR: imm = {{20{b[31]}}, b[31:20]};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/dallanma_birimi_if.sv
// Interface: dallanma_birimi_if
// Bundles the control-flow unit's datapath-facing signals.
//   slave  modport: the unit (inputs bekle_i/buyruk_i/rs1_i/rs2_i, drives the rest)
//   master modport: the surrounding core / memory / register file
// Flow control: bekle_i is a level stall from memory. While it is high the unit
// holds its stage and every register, and all strobes (rd_yaz_o, alindi_o,
// tuzak_o) are forced low; a stage completes only on a rising edge where
// bekle_i is low.
interface dallanma_birimi_if #(
    parameter int XLEN = 32
);
    logic            bekle_i;
    logic [31:0]     buyruk_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [1:0]      asama_o;
    logic [XLEN-1:0] pc_o;
    logic            rd_yaz_o;
    logic [4:0]      rd_idx_o;
    logic [XLEN-1:0] rd_veri_o;
    logic            alindi_o;
    logic            tuzak_o;

    modport slave (
        input  bekle_i, buyruk_i, rs1_i, rs2_i,
        output asama_o, pc_o, rd_yaz_o, rd_idx_o, rd_veri_o, alindi_o, tuzak_o
    );

    modport master (
        output bekle_i, buyruk_i, rs1_i, rs2_i,
        input  asama_o, pc_o, rd_yaz_o, rd_idx_o, rd_veri_o, alindi_o, tuzak_o
    );
endinterface

// File: rtl/dallanma_karsilastirici.sv
// Module: dallanma_karsilastirici
// Combinational branch-condition evaluator.
//   funct3   in  3     branch funct3 field
//   a, b     in  XLEN  rs1 / rs2 values
//   kosul    out 1     condition holds (0 when funct3 is reserved)
//   gecersiz out 1     funct3 is a reserved branch encoding (010/011)
module dallanma_karsilastirici
    import dallanma_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            kosul,
    output logic            gecersiz
);

    always_comb begin
        kosul    = 1'b0;
        gecersiz = 1'b0;
        case (funct3)
            F3_BEQ:  kosul = (a == b);
            F3_BNE:  kosul = (a != b);
            F3_BLT:  kosul = ($signed(a) <  $signed(b));
            F3_BGE:  kosul = ($signed(a) >= $signed(b));
            F3_BLTU: kosul = (a <  b);
            F3_BGEU: kosul = (a >= b);
            default: gecersiz = 1'b1;
        endcase
    end

endmodule

// File: rtl/dallanma_birimi.sv
// Module: dallanma_birimi
// Program counter and control-flow unit of the multicycle core. Runs the
// GETIR -> COZYAZMACOKU -> YURUTGERIYAZ phase machine, owns the PC, resolves
// B-type branches, jal and jalr, produces the link write and traps on
// misaligned targets or reserved branch funct3 values.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of dallanma_birimi_if (stall, instruction, rs1/rs2 in;
//        stage, PC, link write, taken and trap pulses out)
module dallanma_birimi
    import dallanma_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h8000_0100,
    parameter int              IALIGN       = 4
) (
    input  logic             clk,
    input  logic             rst,
    dallanma_birimi_if.slave bus
);

    asama_t          asama_q, asama_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     buyruk_q;
    logic [XLEN-1:0] imm_q;
    tur_t            tur_q;

    logic            kosul, gecersiz;
    logic [XLEN-1:0] pc_arti4, jalr_toplam, hedef;
    logic            atlar, tuzak_var, hizali, etkin, baglanti;

    // Everything freezes while memory asks us to wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asama_q  <= GETIR;
            pc_q     <= RESET_VECTOR;
            buyruk_q <= NOP_BUYRUK;
            imm_q    <= '0;
            tur_q    <= TUR_DIGER;
        end else if (!bus.bekle_i) begin
            asama_q <= asama_d;
            if (asama_q == GETIR) begin
                buyruk_q <= bus.buyruk_i;
            end
            if (asama_q == COZYAZMACOKU) begin
                imm_q <= XLEN'($signed(imm_coz(buyruk_q)));
                tur_q <= tur_coz(buyruk_q[6:0]);
            end
            if (asama_q == YURUTGERIYAZ) begin
                pc_q <= pc_d;
            end
        end
    end

    // Encoding 3 cannot be reached; the default arm steers it back to GETIR.
    always_comb begin
        asama_d = GETIR;
        case (asama_q)
            GETIR:        asama_d = COZYAZMACOKU;
            COZYAZMACOKU: asama_d = YURUTGERIYAZ;
            YURUTGERIYAZ: asama_d = GETIR;
            default:      asama_d = GETIR;
        endcase
    end

    dallanma_karsilastirici #(.XLEN(XLEN)) u_karsilastirici (
        .funct3   (buyruk_q[14:12]),
        .a        (bus.rs1_i),
        .b        (bus.rs2_i),
        .kosul    (kosul),
        .gecersiz (gecersiz)
    );

    assign pc_arti4    = pc_q + XLEN'(4);
    assign jalr_toplam = bus.rs1_i + imm_q;

    always_comb begin
        hedef     = pc_q + imm_q;
        atlar     = 1'b0;
        tuzak_var = 1'b0;
        case (tur_q)
            TUR_DAL: begin
                atlar     = kosul & ~gecersiz;
                tuzak_var = gecersiz;
            end
            TUR_JAL:  atlar = 1'b1;
            TUR_JALR: begin
                atlar = 1'b1;
                hedef = {jalr_toplam[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
        // Only a redirect can misalign; a not-taken branch falls through to pc+4.
        hizali = (IALIGN == 2) ? ~hedef[0] : (hedef[1:0] == 2'b00);
        if (atlar && !hizali) begin
            tuzak_var = 1'b1;
        end
        if (tuzak_var) begin
            pc_d = TRAP_VECTOR;
        end else if (atlar) begin
            pc_d = hedef;
        end else begin
            pc_d = pc_arti4;
        end
    end

    assign etkin    = (asama_q == YURUTGERIYAZ) & ~bus.bekle_i;
    assign baglanti = (tur_q == TUR_JAL) | (tur_q == TUR_JALR);

    assign bus.asama_o   = asama_q;
    assign bus.pc_o      = pc_q;
    assign bus.rd_idx_o  = buyruk_q[11:7];
    assign bus.rd_veri_o = pc_arti4;
    assign bus.rd_yaz_o  = etkin & baglanti & (buyruk_q[11:7] != 5'd0) & ~tuzak_var;
    assign bus.alindi_o  = etkin & atlar & ~tuzak_var;
    assign bus.tuzak_o   = etkin & tuzak_var;

endmodule

// File: tb/tb_dallanma_birimi.sv
// Testbench: tb_dallanma_birimi
// Two instances of the unit (IALIGN=4 and IALIGN=2) receive identical stimulus.
// Expected execute-stage results are produced by a reference model when each
// instruction is driven, queued per instance, and popped in YURUTGERIYAZ.
module tb_dallanma_birimi;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h8000_0100;

    typedef struct packed {
        logic [31:0] pc_next;
        logic        rd_yaz;
        logic [4:0]  rd_idx;
        logic [31:0] rd_veri;
        logic        alindi;
        logic        tuzak;
    } sonuc_t;
    localparam int W = $bits(sonuc_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dallanma_birimi_if #(.XLEN(32)) bus4 ();
    dallanma_birimi_if #(.XLEN(32)) bus2 ();

    dallanma_birimi #(.XLEN(32), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC), .IALIGN(4))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dallanma_birimi #(.XLEN(32), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC), .IALIGN(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp2_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] pc_m, pc2_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one instruction in the execute stage.
    function automatic sonuc_t model(input logic [31:0] pc, input logic [31:0] b,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     input int unsigned ialign);
        sonuc_t s;
        logic [31:0] tgt;
        logic take, res;
        s = '0;
        s.pc_next = pc + 32'd4;
        s.rd_veri = pc + 32'd4;
        s.rd_idx  = b[11:7];
        take = 1'b0;
        res  = 1'b0;
        tgt  = pc + 32'd4;
        case (b[6:0])
            7'h63: begin
                tgt = pc + {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
                case (b[14:12])
                    3'd0: take = (r1 == r2);
                    3'd1: take = (r1 != r2);
                    3'd4: take = ($signed(r1) < $signed(r2));
                    3'd5: take = ($signed(r1) >= $signed(r2));
                    3'd6: take = (r1 < r2);
                    3'd7: take = (r1 >= r2);
                    default: res = 1'b1;
                endcase
            end
            7'h6f: begin
                take = 1'b1;
                tgt  = pc + {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0};
            end
            7'h67: begin
                take = 1'b1;
                tgt  = (r1 + {{20{b[31]}}, b[31:20]}) & 32'hffff_fffe;
            end
            default: ;
        endcase
        if (res) begin
            s.pc_next = TRAP_VEC;
            s.tuzak   = 1'b1;
        end else if (take) begin
            if ((tgt % ialign) != 0) begin
                s.pc_next = TRAP_VEC;
                s.tuzak   = 1'b1;
            end else begin
                s.pc_next = tgt;
                s.alindi  = 1'b1;
                s.rd_yaz  = (b[6:0] != 7'h63) && (b[11:7] != 5'd0);
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd4, 3'b000, rd, 7'h67};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic sur(input logic [31:0] b, input logic [31:0] r1, input logic [31:0] r2);
        bus4.buyruk_i = b;  bus2.buyruk_i = b;
        bus4.rs1_i    = r1; bus2.rs1_i    = r1;
        bus4.rs2_i    = r2; bus2.rs2_i    = r2;
    endtask

    task automatic bekle_sur(input logic v);
        bus4.bekle_i = v;
        bus2.bekle_i = v;
    endtask

    task automatic getir_kontrol(input string ad);
        chk({ad, "_asama4"}, 32'(bus4.asama_o), 32'd0);
        chk({ad, "_asama2"}, 32'(bus2.asama_o), 32'd0);
        chk({ad, "_pc4"}, bus4.pc_o, pc_m);
        chk({ad, "_pc2"}, bus2.pc_o, pc2_m);
        chk({ad, "_strobe4"}, {29'd0, bus4.rd_yaz_o, bus4.alindi_o, bus4.tuzak_o}, 32'd0);
        chk({ad, "_strobe2"}, {29'd0, bus2.rd_yaz_o, bus2.alindi_o, bus2.tuzak_o}, 32'd0);
    endtask

    task automatic sonuc_kontrol(input string ad, input sonuc_t e, input logic yaz,
                                 input logic [4:0] idx, input logic [31:0] veri,
                                 input logic al, input logic tz);
        chk({ad, "_rd_yaz"}, 32'(yaz), 32'(e.rd_yaz));
        chk({ad, "_alindi"}, 32'(al), 32'(e.alindi));
        chk({ad, "_tuzak"}, 32'(tz), 32'(e.tuzak));
        chk({ad, "_rd_veri"}, veri, e.rd_veri);
        if (e.rd_yaz) chk({ad, "_rd_idx"}, 32'(idx), 32'(e.rd_idx));
    endtask

    // Runs one instruction through all three stages; entered and left at a
    // falling edge with the units in GETIR.
    task automatic komut(input string ad, input logic [31:0] b,
                         input logic [31:0] r1, input logic [31:0] r2);
        sonuc_t e4, e2;
        getir_kontrol(ad);
        e4 = model(pc_m, b, r1, r2, 4);
        e2 = model(pc2_m, b, r1, r2, 2);
        exp_q.push_back(W'(e4));
        exp2_q.push_back(W'(e2));
        pc_m  = e4.pc_next;
        pc2_m = e2.pc_next;
        sur(b, $urandom, $urandom);
        @(negedge clk);
        chk({ad, "_coz4"}, 32'(bus4.asama_o), 32'd1);
        chk({ad, "_coz2"}, 32'(bus2.asama_o), 32'd1);
        sur($urandom, $urandom, $urandom);
        @(negedge clk);
        chk({ad, "_yurut4"}, 32'(bus4.asama_o), 32'd2);
        chk({ad, "_yurut2"}, 32'(bus2.asama_o), 32'd2);
        sur($urandom, r1, r2);
        #1;
        if (exp_q.size() == 0 || exp2_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_kuyruk observed=empty expected=entry", ad);
        end else begin
            e4 = sonuc_t'(exp_q.pop_front());
            e2 = sonuc_t'(exp2_q.pop_front());
            sonuc_kontrol({ad, "_d4"}, e4, bus4.rd_yaz_o, bus4.rd_idx_o, bus4.rd_veri_o,
                          bus4.alindi_o, bus4.tuzak_o);
            sonuc_kontrol({ad, "_d2"}, e2, bus2.rd_yaz_o, bus2.rd_idx_o, bus2.rd_veri_o,
                          bus2.alindi_o, bus2.tuzak_o);
        end
        @(negedge clk);
    endtask

    task automatic reset_uygula();
        rst = 1'b0;
        #1;
        pc_m  = RESET_VEC;
        pc2_m = RESET_VEC;
        getir_kontrol("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        bekle_sur(1'b0);
        sur(32'h13, 32'd0, 32'd0);
        @(negedge clk);
        reset_uygula();

        komut("nop",      32'h0000_0013, 32'd0, 32'd0);
        komut("beq_al",   enc_b(3'b000, 13'd16), 32'h0000_0fff, 32'h0000_0fff);
        komut("bltu_yok", enc_b(3'b110, 13'd8), 32'hffff_ffff, 32'd1);
        komut("blt_al",   enc_b(3'b100, 13'd8), 32'hffff_ffff, 32'd1);
        komut("bne_yok",  enc_b(3'b001, 13'd8), 32'd7, 32'd7);
        komut("bge_al",   enc_b(3'b101, 13'h1ff8), 32'd5, 32'hffff_fffd);
        komut("bgeu_yok", enc_b(3'b111, 13'd8), 32'd5, 32'hffff_fffd);
        komut("beq_hiz",  enc_b(3'b000, 13'd6), 32'd1, 32'd2);
        komut("bne_hiz",  enc_b(3'b001, 13'd6), 32'd1, 32'd2);
        komut("f3_010",   enc_b(3'b010, 13'd8), 32'd1, 32'd1);

        reset_uygula();
        komut("jalr",     enc_jalr(5'd5, 12'd512), 32'h8000_1201, 32'd0);
        komut("jal_x0_6", enc_j(5'd0, 21'd6), 32'd0, 32'd0);
        komut("jalr_wrap", enc_jalr(5'd0, 12'h020), 32'hffff_fff0, 32'd0);
        komut("jal_x1",   enc_j(5'd1, 21'd8), 32'd0, 32'd0);
        komut("jal_self", enc_j(5'd3, 21'd0), 32'd0, 32'd0);

        // Stall in COZYAZMACOKU, stall in YURUTGERIYAZ, then reset mid-instruction.
        getir_kontrol("stall_getir");
        sur(enc_b(3'b000, 13'd16), 32'd9, 32'd9);
        @(negedge clk);
        chk("stall_coz", 32'(bus4.asama_o), 32'd1);
        bekle_sur(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_tut_asama", 32'(bus4.asama_o), 32'd1);
            chk("stall_tut_pc", bus4.pc_o, pc_m);
        end
        bekle_sur(1'b0);
        @(negedge clk);
        chk("stall_yurut", 32'(bus4.asama_o), 32'd2);
        bekle_sur(1'b1);
        #1;
        chk("stall_alindi_gated", 32'(bus4.alindi_o), 32'd0);
        @(negedge clk);
        chk("stall_yurut_tut", 32'(bus4.asama_o), 32'd2);
        chk("stall_yurut_pc", bus4.pc_o, pc_m);
        bekle_sur(1'b0);
        #1;
        chk("stall_alindi", 32'(bus4.alindi_o), 32'd1);
        reset_uygula();

        komut("nop_son", 32'h0000_0013, 32'd0, 32'd0);
        getir_kontrol("son");

        chk("kuyruk_bos", 32'(exp_q.size() + exp2_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
